// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS-subset controller:
// state enum, opcodes, datapath mux selects and exception cause codes.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_WB_ALU   = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_WB_MEM   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_JR       = 4'd12,
        S_JAL      = 4'd13,
        S_EXCEPT   = 4'd14
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JR    = 6'b000001;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [2:0] PC_ALU    = 3'b000;
    localparam logic [2:0] PC_ALUOUT = 3'b001;
    localparam logic [2:0] PC_JUMP   = 3'b010;
    localparam logic [2:0] PC_RS     = 3'b011;
    localparam logic [2:0] PC_EXC    = 3'b100;

    localparam logic [1:0] ALUB_B      = 2'b00;
    localparam logic [1:0] ALUB_4      = 2'b01;
    localparam logic [1:0] ALUB_IMM    = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH = 2'b11;

    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MDR = 2'b01;
    localparam logic [1:0] M2R_PC  = 2'b10;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_AND   = 2'b11;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_BUS     = 2'b10;

    function automatic logic is_wait_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_hs_mem_wait_timer.sv
// Counts cycles spent waiting on mem_ready; flags expiry on the last
// allowed cycle so the controller can redirect to the exception vector.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TMO_W       = 4,
    parameter int EXC_EN      = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic waiting,
    input  logic mem_ready,
    output logic expired
);

    localparam bit TMO_ON = (EXC_EN != 0) && (MEM_TIMEOUT != 0);
    localparam logic [TMO_W-1:0] LAST = TMO_W'(MEM_TIMEOUT == 0 ? 0 : MEM_TIMEOUT - 1);

    logic [TMO_W-1:0] count;

    // Saturates so a disabled timeout never wraps back into a match.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (waiting && !mem_ready && count != '1) begin
            count <= count + 1'b1;
        end
    end

    assign expired = TMO_ON && waiting && !mem_ready && (count == LAST);

endmodule

// File: rtl/multicycle_ctrl_hs.sv
// Multicycle MIPS-subset control FSM with a mem_ready handshake, bus timeout
// and illegal-opcode exceptions; opcode is IR[31:26] and is stable after FETCH.
module multicycle_ctrl_hs
    import multicycle_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int TMO_W       = 4,
    parameter int ALU_OP_W    = 2,
    parameter int EXC_EN      = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [5:0]          opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                alusrcA,
    output logic [1:0]          alusrcB,
    output logic [ALU_OP_W-1:0] toaluctrl,
    output logic                memread,
    output logic                memwrite,
    output logic                IorD,
    output logic                IR_write,
    output logic                regwrite,
    output logic [1:0]          regdst,
    output logic [1:0]          memtoreg,
    output logic [2:0]          pcsrc,
    output logic                pc_write,
    output logic                pc_write_condition_beq,
    output logic                pc_write_condition_bne,
    output logic                pc_en,
    output logic                exc_write,
    output logic [1:0]          exc_cause,
    output logic [3:0]          state_o
);

    state_t     state, state_next;
    logic [1:0] cause_next;
    logic [1:0] alu_op;
    logic       expired;

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TMO_W       (TMO_W),
        .EXC_EN      (EXC_EN)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .clr       (state_next != state),
        .waiting   (is_wait_state(state)),
        .mem_ready (mem_ready),
        .expired   (expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            exc_cause <= CAUSE_NONE;
        end else begin
            state     <= state_next;
            exc_cause <= cause_next;
        end
    end

    // mem_ready wins over an expiring timer in the same cycle.
    always_comb begin
        state_next = state;
        cause_next = exc_cause;
        case (state)
            S_IDLE:  state_next = S_FETCH;
            S_FETCH: begin
                if (mem_ready) state_next = S_DECODE;
                else if (expired) begin
                    state_next = S_EXCEPT;
                    cause_next = CAUSE_BUS;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:         state_next = S_EXEC_R;
                    OP_ADDI, OP_ANDI: state_next = S_EXEC_I;
                    OP_LW, OP_SW:     state_next = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:   state_next = S_BRANCH;
                    OP_J:             state_next = S_JUMP;
                    OP_JR:            state_next = S_JR;
                    OP_JAL:           state_next = S_JAL;
                    default: begin
                        if (EXC_EN != 0) begin
                            state_next = S_EXCEPT;
                            cause_next = CAUSE_ILLEGAL;
                        end else begin
                            state_next = S_FETCH;
                        end
                    end
                endcase
            end
            S_EXEC_R, S_EXEC_I: state_next = S_WB_ALU;
            S_MEM_ADDR: state_next = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD, S_MEM_WR: begin
                if (mem_ready) state_next = (state == S_MEM_RD) ? S_WB_MEM : S_FETCH;
                else if (expired) begin
                    state_next = S_EXCEPT;
                    cause_next = CAUSE_BUS;
                end
            end
            S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP, S_JR, S_JAL, S_EXCEPT:
                state_next = S_FETCH;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        alusrcA                = 1'b0;
        alusrcB                = ALUB_B;
        alu_op                 = ALU_ADD;
        memread                = 1'b0;
        memwrite               = 1'b0;
        IorD                   = 1'b0;
        IR_write               = 1'b0;
        regwrite               = 1'b0;
        regdst                 = RD_RT;
        memtoreg               = M2R_ALU;
        pcsrc                  = PC_ALU;
        pc_write               = 1'b0;
        pc_write_condition_beq = 1'b0;
        pc_write_condition_bne = 1'b0;
        exc_write              = 1'b0;
        case (state)
            S_FETCH: begin
                memread  = 1'b1;
                alusrcB  = ALUB_4;
                IR_write = mem_ready;
                pc_write = mem_ready;
            end
            S_DECODE: alusrcB = ALUB_IMM_SH;
            S_EXEC_R: begin
                alusrcA = 1'b1;
                alu_op  = ALU_FUNCT;
            end
            S_EXEC_I: begin
                alusrcA = 1'b1;
                alusrcB = ALUB_IMM;
                alu_op  = (opcode == OP_ANDI) ? ALU_AND : ALU_ADD;
            end
            S_WB_ALU: begin
                regwrite = 1'b1;
                regdst   = (opcode == OP_RTYPE) ? RD_RD : RD_RT;
            end
            S_MEM_ADDR: begin
                alusrcA = 1'b1;
                alusrcB = ALUB_IMM;
            end
            S_MEM_RD: begin
                memread = 1'b1;
                IorD    = 1'b1;
            end
            S_MEM_WR: begin
                memwrite = 1'b1;
                IorD     = 1'b1;
            end
            S_WB_MEM: begin
                regwrite = 1'b1;
                memtoreg = M2R_MDR;
            end
            S_BRANCH: begin
                alusrcA                = 1'b1;
                alu_op                 = ALU_SUB;
                pcsrc                  = PC_ALUOUT;
                pc_write_condition_beq = (opcode == OP_BEQ);
                pc_write_condition_bne = (opcode == OP_BNE);
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pcsrc    = PC_JUMP;
            end
            S_JR: begin
                pc_write = 1'b1;
                pcsrc    = PC_RS;
            end
            S_JAL: begin
                pc_write = 1'b1;
                pcsrc    = PC_JUMP;
                regwrite = 1'b1;
                regdst   = RD_RA;
                memtoreg = M2R_PC;
            end
            S_EXCEPT: begin
                pc_write  = 1'b1;
                pcsrc     = PC_EXC;
                exc_write = 1'b1;
            end
            default: ;
        endcase
    end

    assign toaluctrl = ALU_OP_W'(alu_op);
    assign pc_en     = pc_write | (pc_write_condition_beq & zero) | (pc_write_condition_bne & ~zero);
    assign state_o   = state;

endmodule

// File: doc/multicycle_ctrl_hs.md
Name: multicycle_ctrl_hs

Overview:
Next-generation multicycle MIPS-subset control FSM for the datapath, replacing the fixed-timing controller. It adds a variable-latency memory handshake (mem_ready) with a parametrised bus timeout. It adds illegal-opcode and bus-timeout exceptions that redirect the PC to an exception vector. It also produces a resolved pc_en so the datapath no longer ORs branch conditions itself.

Parameters:
MEM_TIMEOUT, 15, max cycles waiting for mem_ready before bus-error exception; 0 disables the timeout.
TMO_W, 4, timeout counter width; must hold MEM_TIMEOUT.
ALU_OP_W, 2, width of toaluctrl.
EXC_EN, 1, 1 enables exceptions; 0 treats an illegal opcode as NOP (DECODE->FETCH) and waits on memory forever.

Ports:
clk  in  1  clock; all state changes on the rising edge.
reset  in  1  asynchronous, active-high; forces IDLE.
opcode  in  6  IR[31:26].
zero  in  1  ALU zero flag.
mem_ready  in  1  memory completes the access this cycle.
alusrcA  out  1  0=PC, 1=A.
alusrcB  out  2  00=B, 01=4, 10=signext imm, 11=signext imm<<2.
toaluctrl  out  ALU_OP_W  00=add, 01=sub, 10=funct, 11=and.
memread, memwrite  out  1 each  memory strobes.
IorD  out  1  0=PC address, 1=ALUOut address.
IR_write  out  1  IR load.
regwrite  out  1  register file write.
regdst  out  2  00=rt, 01=rd, 10=$31.
memtoreg  out  2  00=ALUOut, 01=MDR, 10=PC.
pcsrc  out  3  000=ALU, 001=ALUOut, 010=jump target, 011=rs, 100=exception vector.
pc_write, pc_write_condition_beq, pc_write_condition_bne  out  1 each  raw PC write controls.
pc_en  out  1  pc_write | (beq_cond & zero) | (bne_cond & ~zero).
exc_write  out  1  EPC/cause load pulse.
exc_cause  out  2  registered; 00=none, 01=illegal opcode, 10=bus timeout.
state_o  out  4  current state, for debug.

Behaviour:
- Moore FSM: outputs decode from the state register only. Exceptions: the handshake-qualified pulses, pc_en (uses zero), and the DECODE/MEM_ADDR next-state decode.
- Any output not listed for a state is 0.
- Reset: async to IDLE with all outputs 0, timeout counter 0, and exc_cause 00. A reset mid-access abandons the access immediately.
- IDLE: all outputs 0 -> FETCH. This gives exactly one idle cycle after reset release.
- FETCH: memread=1, IorD=0, alusrcA=0, alusrcB=01, toaluctrl=00, pcsrc=000.
  - IR_write and pc_write equal mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE on mem_ready=1.
- DECODE: alusrcA=0, alusrcB=11, toaluctrl=00 (branch target to ALUOut). Next state by opcode:
  - 000000 -> EXEC_R
  - 001000 or 001100 -> EXEC_I
  - 100011 or 101011 -> MEM_ADDR
  - 000100 or 000101 -> BRANCH
  - 000010 -> JUMP
  - 000001 -> JR
  - 000011 -> JAL
  - other opcodes -> EXCEPT with cause 01 (or FETCH if EXC_EN=0)
- EXEC_R: alusrcA=1, alusrcB=00, toaluctrl=10 -> WB_ALU.
- EXEC_I: alusrcA=1, alusrcB=10, toaluctrl=00 for addi, 11 for andi -> WB_ALU.
- WB_ALU: regwrite=1, memtoreg=00, regdst=01 for R-type, 00 for I-type -> FETCH.
- MEM_ADDR: alusrcA=1, alusrcB=10, toaluctrl=00 -> MEM_RD for lw, MEM_WR for sw.
- MEM_RD: memread=1, IorD=1; wait for mem_ready -> WB_MEM.
- MEM_WR: memwrite=1, IorD=1; wait for mem_ready -> FETCH.
- WB_MEM: regwrite=1, memtoreg=01, regdst=00 -> FETCH.
- BRANCH: alusrcA=1, alusrcB=00, toaluctrl=01, pcsrc=001; pc_write_condition_beq or _bne per opcode -> FETCH.
- JUMP: pc_write=1, pcsrc=010 -> FETCH.
- JR: pc_write=1, pcsrc=011 -> FETCH.
- JAL: pc_write=1, pcsrc=010, regwrite=1, regdst=10, memtoreg=10 -> FETCH.
- EXCEPT: pc_write=1, pcsrc=100, exc_write=1 -> FETCH. exc_cause updates on the edge entering EXCEPT and holds until the next exception.
- Timeout counter (wait states FETCH, MEM_RD, MEM_WR):
  - Clears to 0 on entry to any wait state and on every state change.
  - Increments each cycle mem_ready=0 while in a wait state.
  - If count==MEM_TIMEOUT-1 and mem_ready=0, next state is EXCEPT with cause 10.
  - mem_ready=1 on that same cycle wins: normal transition, no exception.
  - If MEM_TIMEOUT=0 or EXC_EN=0, the counter saturates and no timeout occurs.
- Timeout during FETCH: IR and PC are not written; EXCEPT then vectors the PC.
- Timeout during MEM_WR: memwrite deasserts when the FSM leaves the state; no register write occurs.

Decomposition:
- Package multicycle_ctrl_pkg holds:
  - the state enum (4-bit, 15 states, IDLE=0)
  - opcode localparams
  - encodings for pcsrc, alusrcB, regdst, memtoreg and toaluctrl
  - the exc_cause codes
- One sub-module, mem_wait_timer: holds the counter, with inputs clr, waiting, mem_ready and output expired.

Test Plan:
- Reset release then lw with mem_ready=1 on first request -> states IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, WB_MEM, FETCH; regwrite=1, memtoreg=01 only in WB_MEM.
- FETCH with mem_ready low for 3 cycles -> IR_write/pc_write=0 for 3 cycles, then 1 for exactly one cycle; no exception.
- beq with zero=1 and zero=0, then bne with zero=0 -> pc_en = 1, 0, 1 in the BRANCH cycle; pcsrc=001.
- opcode 111111 -> EXCEPT next cycle: pc_write=1, pcsrc=100, exc_write=1; exc_cause=01 held through the following FETCH.
- MEM_TIMEOUT=4, sw with mem_ready never asserted -> 4 cycles in MEM_WR, then EXCEPT with exc_cause=10.
- Repeat with mem_ready=1 on the 4th cycle -> FETCH, no exception.
- Assert reset during MEM_RD wait -> outputs 0 in the same cycle, state_o=0.
- Run with EXC_EN=0 and opcode 111111 -> DECODE goes to FETCH, exc_write never asserted.
